spi_sram_responder: RTL

//  SPI-mode-0 responder emulating the delay line's serial SRAM (WRITE 0x02 / READ 0x03, 24-bit address, byte-sequential).

---
 rtl/spi_sram_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a serial SRAM (WRITE 0x02 / READ 0x03, 24-bit address,
// byte-sequential). Pads are oversampled in the clk domain; storage is an inferred byte RAM.
module spi_sram_responder #(
  parameter int         ADDR_W    = 17,
  parameter int         SYNC_STG  = 2,
  parameter logic [7:0] INIT_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        css,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_en,
  output logic        busy,
  output logic        cmd_err,
  output logic [15:0] wr_count
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WRITE, S_READ, S_IGN} state_t;
  state_t state, nstate, estate;

  logic [SYNC_STG-1:0] sck_sy, css_sy, sdi_sy;
  logic                sck_d, css_d, sck_s, css_s, sdi_s;
  logic                sck_r, sck_f, css_f, css_ri, bit_in;
  logic [4:0]          bit_cnt;
  logic [7:0]          sh, sh_nxt;
  logic [23:0]         addr, addr_nxt;
  logic                cmd_rd, cmd_ok;
  logic [ADDR_W-1:0]   idx;
  logic                wr_pend;
  logic [7:0]          wr_data, rd_q, out_sh;
  logic                drv;
  logic [2:0]          ocnt;
  logic [7:0]          mem [0:(2**ADDR_W)-1] = '{default: INIT_BYTE};

  // css chain resets low: a frame already open when rst drops shows no falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sy <= '0;
      css_sy <= '0;
      sdi_sy <= '0;
      sck_d  <= 1'b0;
      css_d  <= 1'b0;
    end else begin
      sck_sy <= SYNC_STG'({sck_sy, sck});
      css_sy <= SYNC_STG'({css_sy, css});
      sdi_sy <= SYNC_STG'({sdi_sy, sdi});
      sck_d  <= sck_s;
      css_d  <= css_s;
    end
  end

  assign sck_s    = sck_sy[SYNC_STG-1];
  assign css_s    = css_sy[SYNC_STG-1];
  assign sdi_s    = sdi_sy[SYNC_STG-1];
  assign sck_r    = sck_s & ~sck_d;
  assign sck_f    = ~sck_s & sck_d;
  assign css_f    = ~css_s & css_d;
  assign css_ri   = css_s & ~css_d;
  // an sck rise coinciding with css fall is bit 0 of the command
  assign bit_in   = sck_r & ~css_ri & ((state != S_IDLE) | css_f);
  assign estate   = (state == S_IDLE) ? S_CMD : state;
  assign sh_nxt   = {sh[6:0], sdi_s};
  assign addr_nxt = {addr[22:0], sdi_s};
  assign cmd_ok   = (sh_nxt == 8'h02) || (sh_nxt == 8'h03);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (css_ri) nstate = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (css_f) nstate = S_CMD;
        S_CMD:   if (bit_in && bit_cnt == 5'd7) nstate = cmd_ok ? S_ADDR : S_IGN;
        S_ADDR:  if (bit_in && bit_cnt == 5'd23) nstate = cmd_rd ? S_READ : S_WRITE;
        default: nstate = state;
      endcase
    end
  end

  always_comb begin
    busy   = (state != S_IDLE);
    sdo_en = (state == S_READ) && drv;
    sdo    = sdo_en && out_sh[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      sh       <= '0;
      addr     <= '0;
      cmd_rd   <= 1'b0;
      idx      <= '0;
      wr_pend  <= 1'b0;
      wr_data  <= '0;
      wr_count <= '0;
      cmd_err  <= 1'b0;
      drv      <= 1'b0;
      out_sh   <= '0;
      ocnt     <= '0;
    end else begin
      cmd_err <= 1'b0;
      wr_pend <= 1'b0;
      if (wr_pend) begin
        idx      <= idx + ADDR_W'(1);
        wr_count <= wr_count + 16'd1;
      end
      if (css_ri) begin
        bit_cnt <= '0;
        drv     <= 1'b0;
        ocnt    <= '0;
      end else if (bit_in) begin
        case (estate)
          S_CMD: begin
            sh <= sh_nxt;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              cmd_rd  <= (sh_nxt == 8'h03);
              cmd_err <= ~cmd_ok;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_ADDR: begin
            addr <= addr_nxt;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              idx     <= addr_nxt[ADDR_W-1:0];
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_WRITE: begin
            sh <= sh_nxt;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              wr_pend <= 1'b1;
              wr_data <= sh_nxt;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          default: ;
        endcase
      end else if (sck_f && state == S_READ) begin
        // rd_q tracks mem[idx]; idx advances while bit 0 is on the wire so the next byte is ready
        if (!drv || ocnt == 3'd7) begin
          out_sh <= rd_q;
          ocnt   <= '0;
          drv    <= 1'b1;
        end else begin
          out_sh <= {out_sh[6:0], 1'b0};
          ocnt   <= ocnt + 3'd1;
          if (ocnt == 3'd6) idx <= idx + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pend) mem[idx] <= wr_data;
    rd_q <= mem[idx];
  end
endmodule
